load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU byte/word access into a single memory-port
// cycle. It waits for the memory, applies timeout and alignment checks, and
// returns a one-cycle response strobe.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_sext,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte_enable,
  output logic        mem_byte_select,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wait,
  output logic [1:0]  state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; the response is the single cycle with resp_valid=1.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic        wr_q, byte_q, sext_q, bsel_q, err_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  cnt_q;
  logic        misaligned;
  logic        timeout;
  logic [15:0] load_val;

  assign misaligned = !req_byte && req_addr[0];
  assign timeout    = mem_wait && ((cnt_q + 8'd1) == LIMIT);

  // Byte reads arrive zero-extended; only the sign fill needs adding here.
  assign load_val = byte_q ? {(sext_q ? {8{mem_rdata[7]}} : 8'h00), mem_rdata[7:0]}
                           : mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = misaligned ? RESP : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (!mem_wait || timeout) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      bsel_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          byte_q  <= req_byte;
          sext_q  <= req_sext;
          bsel_q  <= req_addr[0];
          addr_q  <= {1'b0, req_addr[15:1]};
          wdata_q <= req_wdata;
          rdata_q <= 16'h0000;
          err_q   <= misaligned;
          cnt_q   <= 8'd0;
        end
        WAIT: if (!mem_wait) begin
          cnt_q <= 8'd0;
          if (!wr_q) rdata_q <= load_val;
        end else if (timeout) begin
          cnt_q   <= 8'd0;
          err_q   <= 1'b1;
          rdata_q <= 16'h0000;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_en          = (state_q == ISSUE);
  assign mem_we          = mem_en && wr_q;
  assign mem_byte_enable = byte_q;
  assign mem_byte_select = bsel_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = resp_valid ? rdata_q : 16'h0000;
  assign resp_err        = resp_valid && err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each access is checked against
// hand-computed memory-port fields, response data and cycle latency.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write, req_byte, req_sext;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic        mem_en, mem_we, mem_byte_enable, mem_byte_select;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wait;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_txn call.
  int          o_en_k, o_en_cnt, o_resp_k, o_we_bad;
  logic [15:0] o_rdata, o_maddr, o_mwdata;
  logic        o_err, o_we, o_be, o_bs;

  load_store_unit #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_byte_enable(mem_byte_enable), .mem_byte_select(mem_byte_select),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_wait(mem_wait), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Call at #1 after a rising edge with the unit idle. The memory holds
  // mem_wait high for nwait cycles starting at the first WAIT cycle (E0+2).
  task automatic run_txn(input logic wr, input logic byt, input logic sext,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int nwait);
    o_en_k = 0; o_en_cnt = 0; o_resp_k = 0; o_we_bad = 0;
    o_rdata = 16'hxxxx; o_err = 1'bx;
    req_valid = 1'b1; req_write = wr; req_byte = byt; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      mem_wait  = (k >= 2) && (k < 2 + nwait);
      mem_rdata = rdata;
      @(negedge clk);
      if (mem_we && !mem_en) o_we_bad++;
      if (mem_en) begin
        o_en_cnt++;
        o_en_k   = k;
        o_maddr  = mem_addr;
        o_we     = mem_we;
        o_be     = mem_byte_enable;
        o_bs     = mem_byte_select;
        o_mwdata = mem_wdata;
      end
      if (resp_valid) begin
        o_resp_k = k;
        o_rdata  = resp_rdata;
        o_err    = resp_err;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    mem_wait = 1'b0;
  endtask

  int          acc_k[3];
  int          rsp_k[3];
  logic [15:0] rsp_d[3];
  int          an, rn, late_resp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_sext = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    mem_rdata = 16'h0; mem_wait = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Word store 0x0010 <- 0xBEEF; memory read data must not leak into the response.
    run_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'hFFFF, 0);
    check("st_en_k", 32'(o_en_k), 32'd1);
    check("st_en_cnt", 32'(o_en_cnt), 32'd1);
    check("st_maddr", 32'(o_maddr), 32'h0008);
    check("st_we", 32'(o_we), 32'd1);
    check("st_be", 32'(o_be), 32'd0);
    check("st_wdata", 32'(o_mwdata), 32'hBEEF);
    check("st_resp_k", 32'(o_resp_k), 32'd3);
    check("st_err", 32'(o_err), 32'd0);
    check("st_rdata", 32'(o_rdata), 32'h0000);
    check("st_we_bad", 32'(o_we_bad), 32'd0);

    // Byte loads from 0x0011, sign-extended then zero-extended.
    run_txn(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'h0080, 0);
    check("lbs_maddr", 32'(o_maddr), 32'h0008);
    check("lbs_bs", 32'(o_bs), 32'd1);
    check("lbs_be", 32'(o_be), 32'd1);
    check("lbs_we", 32'(o_we), 32'd0);
    check("lbs_rdata", 32'(o_rdata), 32'hFF80);
    check("lbs_resp_k", 32'(o_resp_k), 32'd3);
    run_txn(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0080, 0);
    check("lbu_rdata", 32'(o_rdata), 32'h0080);
    run_txn(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'h007F, 0);
    check("lbs_pos_rdata", 32'(o_rdata), 32'h007F);
    check("lbs_pos_bs", 32'(o_bs), 32'd0);

    // Misaligned word load.
    run_txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h5555, 0);
    check("mis_en_cnt", 32'(o_en_cnt), 32'd0);
    check("mis_resp_k", 32'(o_resp_k), 32'd1);
    check("mis_err", 32'(o_err), 32'd1);
    check("mis_rdata", 32'(o_rdata), 32'h0000);

    // Two wait cycles, then data.
    run_txn(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, 2);
    check("w2_maddr", 32'(o_maddr), 32'h0002);
    check("w2_resp_k", 32'(o_resp_k), 32'd5);
    check("w2_rdata", 32'(o_rdata), 32'h1234);
    check("w2_err", 32'(o_err), 32'd0);

    // Memory never ready: timeout after 15 wait cycles (WAIT entered at E0+2).
    run_txn(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 16'hAAAA, 50);
    check("to_resp_k", 32'(o_resp_k), 32'd17);
    check("to_err", 32'(o_err), 32'd1);
    check("to_rdata", 32'(o_rdata), 32'h0000);
    check("to_en_cnt", 32'(o_en_cnt), 32'd1);

    // Byte store to odd address; fields must hold afterwards.
    run_txn(1'b1, 1'b1, 1'b0, 16'h0021, 16'h12C3, 16'h0000, 0);
    check("sb_maddr", 32'(o_maddr), 32'h0010);
    check("sb_bs", 32'(o_bs), 32'd1);
    check("sb_be", 32'(o_be), 32'd1);
    check("sb_wdata", 32'(o_mwdata), 32'h12C3);
    check("sb_rdata", 32'(o_rdata), 32'h0000);
    @(negedge clk);
    check("hold_maddr", 32'(mem_addr), 32'h0010);
    check("hold_wdata", 32'(mem_wdata), 32'h12C3);
    check("hold_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;

    // Reset while in WAIT abandons the transaction.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0040;
    @(posedge clk);
    #1 req_valid = 1'b0; mem_wait = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rw_in_wait", 32'(state_dbg), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    check("rw_ready", 32'(req_ready), 32'd1);
    check("rw_mem_en", 32'(mem_en), 32'd0);
    check("rw_mem_we", 32'(mem_we), 32'd0);
    check("rw_maddr", 32'(mem_addr), 32'd0);
    late_resp = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid || mem_en) late_resp++;
      @(negedge clk);
    end
    check("rw_no_resp", 32'(late_resp), 32'd0);
    @(posedge clk);
    #1;

    // req_valid held high for three aligned word loads.
    an = 0; rn = 0;
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0008;
    for (int k = 0; k < 30; k++) begin
      mem_wait  = 1'b0;
      mem_rdata = 16'hA000 + 16'(an);
      @(negedge clk);
      if (resp_valid && rn < 3) begin
        rsp_k[rn] = k; rsp_d[rn] = resp_rdata; rn++;
      end
      if (req_valid && req_ready && an < 3) begin
        acc_k[an] = k; an++;
      end
      @(posedge clk);
      #1;
      if (an == 3) req_valid = 1'b0;
    end
    check("b2b_acc_n", 32'(an), 32'd3);
    check("b2b_resp_n", 32'(rn), 32'd3);
    check("b2b_gap0", 32'(acc_k[1] - acc_k[0]), 32'd4);
    check("b2b_gap1", 32'(acc_k[2] - acc_k[1]), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("b2b_resp_k", 32'(rsp_k[i] - acc_k[i]), 32'd3);
      check("b2b_resp_d", 32'(rsp_d[i]), 32'(16'hA001 + 16'(i)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
